decode_stage: RTL

Registered, handshaked instruction-decode stage between fetch and execute in the 16-bit core. Each accepted instruction is decoded once into execute-opcode, operand indices, immediate and destination fields and held in an output register until execute takes it. A per-register scoreboard stalls issue on read-after-write and write-after-write hazards until writeback clears them. Register-index and immediate widths are parametrised, and undefined opcodes are flagged rather than silently passed.

---
 rtl/decode_stage_pkg.sv | 29 ++
 rtl/decode_stage_table.sv | 57 +++++
 rtl/decode_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared opcodes, field widths and decode control record
package decode_stage_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OC_MOV  = 4'h1,
    OC_MOVI = 4'h2,
    OC_ADD  = 4'h3,
    OC_ADDI = 4'h4
  } instOpcode_e;

  typedef enum logic [OPCODE_W-1:0] {
    EX_OC_NONE = 4'h0,
    EX_OC_MOV  = 4'h1,
    EX_OC_ADD  = 4'h2
  } exeOpcode_e;

  // Fixed-width part of a decoded instruction; index/immediate widths live in the modules.
  typedef struct packed {
    logic [OPCODE_W-1:0] exeOpcode;
    logic                srcIsImm;
    logic                illegal;
    logic                readIn1;
    logic                readIn2;
    logic                writesDest;
  } decodeCtrl_t;

endpackage

// File: rtl/decode_stage_table.sv
// rtl/decode_stage_table.sv - combinational instruction to decoded-field table
// Undefined opcodes yield an all-zero control record except the illegal flag.
module decode_stage_table
  import decode_stage_pkg::*;
#(
  parameter int INST_W    = 16,
  parameter int REG_IDX_W = 2,
  parameter int IMM_W     = 8
) (
  input  logic [INST_W-1:0]    instruction,
  output decodeCtrl_t          ctrl,
  output logic [REG_IDX_W-1:0] in1Idx,
  output logic [REG_IDX_W-1:0] in2Idx,
  output logic [IMM_W-1:0]     immVal
);

  if (INST_W < OPCODE_W + 2 * REG_IDX_W + IMM_W) begin : gBadLayout
    $error("decode_stage_table: INST_W cannot hold opcode, two register indices and immediate");
  end

  logic [OPCODE_W-1:0] opcode;

  assign opcode = instruction[INST_W-1 -: OPCODE_W];
  assign in1Idx = instruction[INST_W-OPCODE_W-1 -: REG_IDX_W];
  assign in2Idx = instruction[INST_W-OPCODE_W-REG_IDX_W-1 -: REG_IDX_W];
  assign immVal = instruction[IMM_W-1:0];

  always_comb begin
    ctrl = '0;
    case (opcode)
      OC_MOV: begin
        ctrl.exeOpcode  = EX_OC_MOV;
        ctrl.readIn2    = 1'b1;
        ctrl.writesDest = 1'b1;
      end
      OC_MOVI: begin
        ctrl.exeOpcode  = EX_OC_MOV;
        ctrl.srcIsImm   = 1'b1;
        ctrl.writesDest = 1'b1;
      end
      OC_ADD: begin
        ctrl.exeOpcode  = EX_OC_ADD;
        ctrl.readIn1    = 1'b1;
        ctrl.readIn2    = 1'b1;
        ctrl.writesDest = 1'b1;
      end
      OC_ADDI: begin
        ctrl.exeOpcode  = EX_OC_ADD;
        ctrl.srcIsImm   = 1'b1;
        ctrl.readIn1    = 1'b1;
        ctrl.writesDest = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with handshake and hazard scoreboard
// The scoreboard and hazard stall exist only when DECODE_SCOREBOARD_EN is defined.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int INST_W    = 16,
  parameter int REG_IDX_W = 2,
  parameter int IMM_W     = 8
) (
  input  logic                 iCLOCK,
  input  logic                 iRESET_SYNC,
  input  logic                 iFLUSH,
  input  logic                 iVALID,
  output logic                 oREADY,
  input  logic [INST_W-1:0]    iINSTRUCTION,
  output logic                 oVALID,
  input  logic                 iEXE_READY,
  output logic [OPCODE_W-1:0]  oDECODE_EXE_OPCODE,
  output logic [REG_IDX_W-1:0] oDECODE_IN1_IDX,
  output logic [REG_IDX_W-1:0] oDECODE_IN2_IDX,
  output logic [IMM_W-1:0]     oDECODE_IMM_VAL,
  output logic [REG_IDX_W-1:0] oDECODE_DEST_IDX,
  output logic                 oDECODE_SRC1_IS_REG_OR_IMM,
  output logic                 oDECODE_ILLEGAL,
  input  logic                 iWB_VALID,
  input  logic [REG_IDX_W-1:0] iWB_IDX
);

  decodeCtrl_t          ctrl;
  logic [REG_IDX_W-1:0] in1Idx;
  logic [REG_IDX_W-1:0] in2Idx;
  logic [IMM_W-1:0]     immVal;
  logic                 hazard;
  logic                 accept;

  decode_stage_table #(
    .INST_W   (INST_W),
    .REG_IDX_W(REG_IDX_W),
    .IMM_W    (IMM_W)
  ) uTable (
    .instruction(iINSTRUCTION),
    .ctrl       (ctrl),
    .in1Idx     (in1Idx),
    .in2Idx     (in2Idx),
    .immVal     (immVal)
  );

  assign oREADY = (!oVALID || iEXE_READY) && !hazard && !iFLUSH;
  assign accept = iVALID && oREADY;

`ifdef DECODE_SCOREBOARD_EN
  localparam int numRegs = 2 ** REG_IDX_W;

  logic [numRegs-1:0] pending;
  logic [numRegs-1:0] pendingNext;
  logic               heldOwnsPending;

  // Destination is always in1, so WAW and the in1 read share one lookup.
  assign hazard = (ctrl.writesDest && pending[in1Idx]) ||
                  (ctrl.readIn1 && pending[in1Idx]) ||
                  (ctrl.readIn2 && pending[in2Idx]);

  always_comb begin
    pendingNext = pending;
    if (iWB_VALID) pendingNext[iWB_IDX] = 1'b0;
    if (iFLUSH && oVALID && heldOwnsPending) pendingNext[oDECODE_DEST_IDX] = 1'b0;
    if (accept && ctrl.writesDest) pendingNext[in1Idx] = 1'b1;
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      pending         <= '0;
      heldOwnsPending <= 1'b0;
    end else begin
      pending <= pendingNext;
      if (accept) heldOwnsPending <= ctrl.writesDest;
      else if (iFLUSH || iEXE_READY) heldOwnsPending <= 1'b0;
    end
  end
`else
  logic unusedScoreboardInputs;

  assign hazard = 1'b0;
  assign unusedScoreboardInputs = ^{iWB_VALID, iWB_IDX, ctrl.readIn1, ctrl.readIn2, ctrl.writesDest};
`endif

  // Fields load only on accept, so they stay stable while execute back-pressures.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      oVALID                     <= 1'b0;
      oDECODE_EXE_OPCODE         <= '0;
      oDECODE_IN1_IDX            <= '0;
      oDECODE_IN2_IDX            <= '0;
      oDECODE_IMM_VAL            <= '0;
      oDECODE_DEST_IDX           <= '0;
      oDECODE_SRC1_IS_REG_OR_IMM <= 1'b0;
      oDECODE_ILLEGAL            <= 1'b0;
    end else if (accept) begin
      oVALID                     <= 1'b1;
      oDECODE_EXE_OPCODE         <= ctrl.exeOpcode;
      oDECODE_IN1_IDX            <= in1Idx;
      oDECODE_IN2_IDX            <= in2Idx;
      oDECODE_IMM_VAL            <= immVal;
      oDECODE_DEST_IDX           <= in1Idx;
      oDECODE_SRC1_IS_REG_OR_IMM <= ctrl.srcIsImm;
      oDECODE_ILLEGAL            <= ctrl.illegal;
    end else if (iFLUSH || iEXE_READY) begin
      oVALID <= 1'b0;
    end
  end

endmodule
